ex_mdu: RTL
===========

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32, operand and result width (even, >=8).
REQ-002 The block SHALL provide parameter TAGW, default 5, width of the destination-register tag carried with each operation.
REQ-003 The block SHALL provide parameter FAST_MUL, default 0; when 1, MUL/MULH/MULHSU/MULHU complete in one cycle.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
 clk  in  1  clock, rising edge
 rst  in  1  asynchronous reset, active-low
 flush  in  1  abort in-flight operation (pipeline redirect)
 in_valid  in  1  operation offered
 in_ready  out  1  operation accepted when in_valid && in_ready
 in_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
 in_a  in  XLEN  rs1 operand
 in_b  in  XLEN  rs2 operand
 in_tag  in  TAGW  destination register number
 out_valid  out  1  result available
 out_ready  in  1  result consumed when out_valid && out_ready
 out_result  out  XLEN  result
 out_tag  out  TAGW  tag of the result
 busy  out  1  high in BUSY or DONE (used for EX stall)

Function
REQ-006 The block SHALL implement states IDLE, BUSY, DONE.
REQ-007 in_ready SHALL equal !flush && (state==IDLE || (state==DONE && out_ready)).
REQ-008 On accept, operands, op and tag SHALL be registered; the block SHALL NOT sample in_* in any other cycle.
REQ-009 Iterative ops (all ops when FAST_MUL=0, DIV/REM family always) SHALL go to BUSY with a counter loaded to XLEN, decrement once per BUSY cycle, and enter DONE on the cycle after the counter reaches 1; accept at cycle T gives out_valid at T+XLEN+1.
REQ-010 Multiply SHALL be radix-2 shift-add over |a|,|b| with a 2*XLEN product; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits after sign correction (MULH a,b signed; MULHSU a signed, b unsigned; MULHU both unsigned).
REQ-011 Divide SHALL be restoring radix-2 on magnitudes; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a), for signed ops only.
REQ-012 Divide by zero SHALL bypass BUSY and reach DONE at T+1: DIV/DIVU result all-ones, REM/REMU result = in_a.
REQ-013 Signed overflow (a = -2^(XLEN-1), b = -1) SHALL reach DONE at T+1: DIV result = in_a, REM result = 0.
REQ-014 With FAST_MUL=1, multiply ops SHALL reach DONE at T+1 with results identical to REQ-010.
REQ-015 In DONE, out_valid SHALL be 1 and out_result/out_tag SHALL remain stable until out_ready is 1.
REQ-016 DONE with out_ready=1 and no accept SHALL go to IDLE; with a simultaneous accept it SHALL start the new op directly (back-to-back, no bubble).
REQ-017 flush=1 SHALL force state to IDLE on the next edge from any state, discard the in-flight result, and block acceptance in that cycle; out_valid SHALL be 0 from the next cycle.
REQ-018 out_valid SHALL be 0 in IDLE and BUSY; busy SHALL be 0 only in IDLE.

Reset
REQ-019 While rst=0, state SHALL be IDLE, counter 0, out_valid 0, busy 0, out_result 0, out_tag 0, in_ready 1 (flush=0), asynchronously, including mid-operation.
REQ-020 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-021 XLEN=32, FAST_MUL=0: MUL a=7, b=0xFFFFFFFD accepted at T -> out_valid at T+33, result 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
REQ-022 DIV a=0x80000000, b=0xFFFFFFFF -> out_valid at T+1, result 0x80000000; REM -> 0x00000000; DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 0x00000005.
REQ-023 DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; out_tag equals accepted in_tag.
REQ-024 out_ready held 0 for 3 cycles after DONE -> result and tag stable, in_ready 0; then out_ready=1 with in_valid=1 -> new op accepted same cycle, next out_valid exactly XLEN+1 cycles later.
REQ-025 flush in 10th BUSY cycle -> no out_valid, in_ready 1 the following cycle; rst=0 mid-BUSY -> outputs zero immediately, next op after release gives correct result.
REQ-026 FAST_MUL=1: MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid at T+1, result 0xFFFFFFFF.

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu: RV32M-style multiply/divide execution unit.
// Multiplies are shift-add over operand magnitudes, or single-cycle when
// FAST_MUL=1. Divides are restoring radix-2 over magnitudes. Divide-by-zero
// and signed overflow skip the iterative datapath. Each result carries the
// destination tag that was accepted with its operation.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   flush             abort any in-flight operation
//   in_valid/in_ready operation handshake; in_op is RV32M funct3
//   in_a, in_b        rs1/rs2 operands; in_tag destination register
//   out_valid/out_ready result handshake; out_result, out_tag
//   busy              high whenever an operation is in flight or unconsumed
module ex_mdu #(
  parameter int XLEN     = 32,
  parameter int TAGW     = 5,
  parameter int FAST_MUL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int XW = 2 * XLEN;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [XW-1:0]   acc, acc_next;
  logic [XLEN-1:0] opnd;
  logic [2:0]      op_q;
  logic            res_neg;
  logic [XLEN-1:0] res;
  logic [TAGW-1:0] tag_q;

  logic            accept, is_mul, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, fast_path, acc_neg;
  logic [XLEN-1:0] mag_a, mag_b, fast_result;
  logic [XW-1:0]   fast_prod;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  // Turns a raw magnitude result into the architectural result: a signed
  // 2*XLEN product for multiplies, or {remainder, quotient} for divides.
  function automatic logic [XLEN-1:0] finalize(input logic [2:0] op,
                                               input logic neg,
                                               input logic [XW-1:0] raw);
    logic [XW-1:0]   prod;
    logic [XLEN-1:0] quo, rem;
    prod = neg ? -raw : raw;
    quo  = neg ? -raw[XLEN-1:0] : raw[XLEN-1:0];
    rem  = neg ? -raw[XW-1:XLEN] : raw[XW-1:XLEN];
    if (!op[2]) finalize = (op == 3'd0) ? prod[XLEN-1:0] : prod[XW-1:XLEN];
    else        finalize = op[1] ? rem : quo;
  endfunction

  assign accept   = in_valid && in_ready;
  assign is_mul   = !in_op[2];
  assign a_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
  assign b_signed = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
  assign a_neg    = a_signed && in_a[XLEN-1];
  assign b_neg    = b_signed && in_b[XLEN-1];
  assign mag_a    = a_neg ? -in_a : in_a;
  assign mag_b    = b_neg ? -in_b : in_b;
  assign div_zero = in_op[2] && (in_b == '0);
  assign div_ovf  = ((in_op == 3'd4) || (in_op == 3'd6)) &&
                    (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
  assign fast_path = div_zero || div_ovf || ((FAST_MUL != 0) && is_mul);
  // Remainder follows the dividend's sign; everything else uses a XOR b.
  assign acc_neg  = (in_op[2] && in_op[1]) ? a_neg : (a_neg ^ b_neg);

  // Results that complete one cycle after accept. The multiplier only exists
  // when FAST_MUL is set because the branch is constant-folded otherwise.
  always_comb begin
    fast_prod = XW'(mag_a) * XW'(mag_b);
    if (div_zero)           fast_result = in_op[1] ? in_a : '1;
    else if (div_ovf)       fast_result = in_op[1] ? '0 : in_a;
    else if (FAST_MUL != 0) fast_result = finalize(in_op, acc_neg, fast_prod);
    else                    fast_result = '0;
  end

  // One iteration of either algorithm. Multiply keeps {partial, multiplier}
  // and shifts right; divide keeps {remainder, quotient} and shifts left,
  // keeping the trial difference only when it did not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc[XW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[XW-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (op_q[2]) begin
      if (div_diff[XLEN]) acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else                acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = fast_path ? DONE : BUSY;
      BUSY:    if (cnt == CW'(1)) next_state = DONE;
      DONE: begin
        if (accept)         next_state = fast_path ? DONE : BUSY;
        else if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_comb begin
    in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Operands are captured only on accept; the result register is written
  // only on accept or on the final iteration, so it holds steady in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      op_q    <= '0;
      res_neg <= 1'b0;
      res     <= '0;
      tag_q   <= '0;
    end else if (accept) begin
      op_q    <= in_op;
      tag_q   <= in_tag;
      res_neg <= acc_neg;
      if (fast_path) begin
        res <= fast_result;
        cnt <= '0;
      end else begin
        cnt  <= CW'(XLEN);
        opnd <= is_mul ? mag_a : mag_b;
        acc  <= {{XLEN{1'b0}}, (is_mul ? mag_b : mag_a)};
      end
    end else if (flush) begin
      cnt <= '0;
    end else if (state == BUSY) begin
      acc <= acc_next;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) res <= finalize(op_q, res_neg, acc_next);
    end
  end

  assign out_result = res;
  assign out_tag    = tag_q;

endmodule
